// File: rtl/xdma_pkg.sv
// Shared types for the xDMA read data path.
// Descriptor layout, AXI response codes and FSM states.
package xdma_pkg;

  typedef struct packed {
    logic [7:0] num_beats;
    logic       is_single;
    logic       is_read_data;
  } xdma_req_r_desc_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } r_state_e;

endpackage

// File: rtl/counter.sv
// Free-running up counter with synchronous clear and enable.
// Wraps naturally at 2**WIDTH.
module counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= q_o + 1'b1;
    end
  end

endmodule

// File: rtl/xdma_r_spill_reg.sv
// Two-entry valid/ready buffer carrying data plus a last flag.
// Full throughput at one cycle latency; ready is registered-only.
module xdma_r_spill_reg #(
  parameter type data_t = logic [31:0]
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  valid_i,
  output logic  ready_o,
  input  data_t data_i,
  input  logic  last_i,
  output logic  valid_o,
  input  logic  ready_i,
  output data_t data_o,
  output logic  last_o,
  output logic  empty_o
);

  data_t      mem_q  [2];
  logic       last_q [2];
  logic       wr_q;
  logic       rd_q;
  logic [1:0] cnt_q;
  logic       push;
  logic       pop;

  assign ready_o = (cnt_q != 2'd2);
  assign valid_o = (cnt_q != 2'd0);
  assign empty_o = (cnt_q == 2'd0);
  assign push    = valid_i && ready_o;
  assign pop     = valid_o && ready_i;
  assign data_o  = valid_o ? mem_q[rd_q] : '0;
  assign last_o  = valid_o && last_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i]  <= '0;
        last_q[i] <= 1'b0;
      end
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_q]  <= data_i;
        last_q[wr_q] <= last_i;
        wr_q         <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/xdma_r_data_path.sv
// xDMA read data path: AXI R beats to local stream, last from descriptor.
// Define XDMA_R_SPILL_EN to insert a 2-entry spill register on the stream.
module xdma_r_data_path
  import xdma_pkg::*;
#(
  parameter type data_t = logic [31:0]
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  xdma_req_r_desc_t r_desc_i,
  input  logic             r_dp_valid_i,
  output logic             r_dp_ready_o,
  input  data_t            r_data_i,
  input  logic [1:0]       r_resp_i,
  input  logic             r_last_i,
  input  logic             r_valid_i,
  output logic             r_ready_o,
  output data_t            read_rsp_data_o,
  output logic             read_rsp_last_o,
  output logic             read_rsp_valid_o,
  input  logic             read_rsp_ready_i,
  output logic             err_last_o,
  output logic             err_resp_o,
  input  logic             err_clear_i
);

  r_state_e   state_q;
  r_state_e   state_d;
  logic [7:0] cnt;
  logic       busy;
  logic       rd;
  logic       exp_last;
  logic       beat;
  logic       done;
  logic       start;
  logic       err_last_q;
  logic       err_resp_q;
  logic       resp_bad;

  assign busy     = (state_q == BUSY) && !rst_i;
  assign rd       = r_desc_i.is_read_data;
  assign exp_last = r_desc_i.is_single ||
                    (cnt == r_desc_i.num_beats - 8'd1);
  assign beat     = busy && r_valid_i && r_ready_o;
  assign resp_bad = (r_resp_i == RESP_SLVERR) ||
                    (r_resp_i == RESP_DECERR);

  counter #(
    .WIDTH (8)
  ) i_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (start || done),
    .en_i    (beat),
    .q_o     (cnt)
  );

`ifdef XDMA_R_SPILL_EN
  logic  sp_ready;
  logic  sp_valid;
  logic  sp_last;
  logic  sp_empty;
  data_t sp_data;
  logic  wait_q;

  // Once the last beat is buffered, stop taking R beats until it drains.
  always_ff @(posedge clk_i) begin
    if (rst_i || done) begin
      wait_q <= 1'b0;
    end else if (beat && rd && exp_last) begin
      wait_q <= 1'b1;
    end
  end

  xdma_r_spill_reg #(
    .data_t (data_t)
  ) i_spill (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (beat && rd),
    .ready_o (sp_ready),
    .data_i  (r_data_i),
    .last_i  (exp_last),
    .valid_o (sp_valid),
    .ready_i (read_rsp_ready_i),
    .data_o  (sp_data),
    .last_o  (sp_last),
    .empty_o (sp_empty)
  );

  assign start = (state_q == IDLE) && r_dp_valid_i && sp_empty;

  always_comb begin
    r_ready_o        = 1'b0;
    read_rsp_valid_o = 1'b0;
    read_rsp_data_o  = '0;
    read_rsp_last_o  = 1'b0;
    done             = 1'b0;
    if (busy) begin
      r_ready_o        = !rd || (sp_ready && !wait_q);
      read_rsp_valid_o = sp_valid;
      read_rsp_data_o  = sp_data;
      read_rsp_last_o  = sp_last;
      done             = rd ? (sp_valid && read_rsp_ready_i && sp_last)
                            : (beat && exp_last);
    end
  end
`else
  assign start = (state_q == IDLE) && r_dp_valid_i;

  always_comb begin
    r_ready_o        = 1'b0;
    read_rsp_valid_o = 1'b0;
    read_rsp_data_o  = '0;
    read_rsp_last_o  = 1'b0;
    if (busy) begin
      if (rd) begin
        r_ready_o        = read_rsp_ready_i;
        read_rsp_valid_o = r_valid_i;
        read_rsp_data_o  = r_data_i;
        read_rsp_last_o  = exp_last;
      end else begin
        r_ready_o = 1'b1;
      end
    end
  end

  assign done = beat && exp_last;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Set wins over clear; a new descriptor leaves the flags alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_last_q <= 1'b0;
      err_resp_q <= 1'b0;
    end else begin
      if (beat && (r_last_i != exp_last)) err_last_q <= 1'b1;
      else if (err_clear_i)               err_last_q <= 1'b0;
      if (beat && resp_bad)               err_resp_q <= 1'b1;
      else if (err_clear_i)               err_resp_q <= 1'b0;
    end
  end

  assign r_dp_ready_o = done;
  assign err_last_o   = err_last_q && !rst_i;
  assign err_resp_o   = err_resp_q && !rst_i;

  assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == BUSY) |-> r_dp_valid_i)
    else $error("descriptor valid dropped while busy");

endmodule

// File: tb/tb_xdma_r_data_path.sv
// Randomized bench for xdma_r_data_path (pass-through build).
// Reference model works per descriptor on beat indices and sticky flags.
module tb_xdma_r_data_path;
  import xdma_pkg::*;

  typedef logic [31:0] data_t;

  logic             clk_i = 1'b0;
  logic             rst_i;
  xdma_req_r_desc_t r_desc_i;
  logic             r_dp_valid_i;
  logic             r_dp_ready_o;
  data_t            r_data_i;
  logic [1:0]       r_resp_i;
  logic             r_last_i;
  logic             r_valid_i;
  logic             r_ready_o;
  data_t            read_rsp_data_o;
  logic             read_rsp_last_o;
  logic             read_rsp_valid_o;
  logic             read_rsp_ready_i;
  logic             err_last_o;
  logic             err_resp_o;
  logic             err_clear_i;

  int   total = 0;
  int   bad   = 0;
  logic m_el  = 1'b0;
  logic m_er  = 1'b0;

  always #5 clk_i = ~clk_i;

  xdma_r_data_path #(
    .data_t (data_t)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .r_desc_i         (r_desc_i),
    .r_dp_valid_i     (r_dp_valid_i),
    .r_dp_ready_o     (r_dp_ready_o),
    .r_data_i         (r_data_i),
    .r_resp_i         (r_resp_i),
    .r_last_i         (r_last_i),
    .r_valid_i        (r_valid_i),
    .r_ready_o        (r_ready_o),
    .read_rsp_data_o  (read_rsp_data_o),
    .read_rsp_last_o  (read_rsp_last_o),
    .read_rsp_valid_o (read_rsp_valid_o),
    .read_rsp_ready_i (read_rsp_ready_i),
    .err_last_o       (err_last_o),
    .err_resp_o       (err_resp_o),
    .err_clear_i      (err_clear_i)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_r_ready"}, 32'(r_ready_o), 32'd0);
    check({tag, "_valid"},   32'(read_rsp_valid_o), 32'd0);
    check({tag, "_last"},    32'(read_rsp_last_o), 32'd0);
    check({tag, "_data"},    read_rsp_data_o, 32'd0);
    check({tag, "_dp_rdy"},  32'(r_dp_ready_o), 32'd0);
    check({tag, "_err_l"},   32'(err_last_o), 32'(m_el));
    check({tag, "_err_r"},   32'(err_resp_o), 32'(m_er));
  endtask

  // One descriptor: n beats, last expected on beat n-1 only.
  task automatic run_desc(input logic [7:0] nb, input logic single,
                          input logic rd, input bit inject,
                          input int rst_at);
    int n;
    int sent;
    int cyc;
    bit done;
    bit exp_rdy;
    bit acc;
    bit last_i;
    bit set_l;
    bit set_r;
    n = single ? 1 : (nb == 8'd0 ? 256 : int'(nb));
    r_desc_i = '{num_beats: nb, is_single: single, is_read_data: rd};
    r_dp_valid_i = 1'b1;
    sent = 0;
    cyc  = 0;
    done = 1'b0;
    while (!done) begin
      r_valid_i        = (sent < n) && ($urandom_range(3) != 0);
      r_data_i         = $urandom;
      last_i           = (sent == n - 1);
      r_last_i         = last_i ^ (inject && $urandom_range(4) == 0);
      r_resp_i         = inject ? 2'($urandom_range(3))
                                : {1'b0, 1'($urandom_range(1))};
      read_rsp_ready_i = $urandom_range(3) != 0;
      err_clear_i      = $urandom_range(11) == 0;
      rst_i            = (rst_at >= 0) && (sent == rst_at) && (cyc > 0);
      @(negedge clk_i);
      if (rst_i) begin
        @(posedge clk_i);
        #1;
        rst_i        = 1'b0;
        r_dp_valid_i = 1'b0;
        r_valid_i    = 1'b0;
        err_clear_i  = 1'b0;
        m_el         = 1'b0;
        m_er         = 1'b0;
        @(negedge clk_i);
        check_idle("after_rst");
        @(posedge clk_i);
        #1;
        return;
      end
      check("err_last", 32'(err_last_o), 32'(m_el));
      check("err_resp", 32'(err_resp_o), 32'(m_er));
      exp_rdy = (cyc == 0) ? 1'b0 : (rd ? read_rsp_ready_i : 1'b1);
      check("r_ready", 32'(r_ready_o), 32'(exp_rdy));
      check("rsp_valid", 32'(read_rsp_valid_o),
            32'((cyc != 0) && rd && r_valid_i));
      acc   = r_valid_i && exp_rdy;
      set_l = 1'b0;
      set_r = 1'b0;
      if (acc) begin
        if (rd) begin
          check("rsp_data", read_rsp_data_o, r_data_i);
          check("rsp_last", 32'(read_rsp_last_o), 32'(last_i));
        end
        set_l = (r_last_i != last_i);
        set_r = r_resp_i[1];
        sent++;
        done = last_i;
      end
      check("dp_ready", 32'(r_dp_ready_o), 32'(acc && last_i));
      m_el = set_l ? 1'b1 : (err_clear_i ? 1'b0 : m_el);
      m_er = set_r ? 1'b1 : (err_clear_i ? 1'b0 : m_er);
      @(posedge clk_i);
      #1;
      cyc++;
      if (!done && cyc > 3000) begin
        check("timeout", 32'd1, 32'd0);
        done = 1'b1;
      end
    end
    r_valid_i   = 1'b0;
    err_clear_i = 1'b0;
  endtask

  initial begin
    rst_i            = 1'b1;
    r_desc_i         = '0;
    r_dp_valid_i     = 1'b0;
    r_data_i         = '0;
    r_resp_i         = RESP_OKAY;
    r_last_i         = 1'b0;
    r_valid_i        = 1'b0;
    read_rsp_ready_i = 1'b0;
    err_clear_i      = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check_idle("reset");
    @(posedge clk_i);
    #1;

    run_desc(8'd4, 1'b0, 1'b1, 1'b0, -1);
    run_desc(8'd4, 1'b0, 1'b1, 1'b0, -1);
    run_desc(8'd2, 1'b0, 1'b0, 1'b0, -1);
    run_desc(8'd3, 1'b0, 1'b1, 1'b1, -1);
    run_desc(8'd0, 1'b0, 1'b1, 1'b0, -1);
    run_desc(8'd1, 1'b1, 1'b1, 1'b1, -1);
    run_desc(8'd5, 1'b1, 1'b0, 1'b1, -1);
    run_desc(8'd4, 1'b0, 1'b1, 1'b0, 2);
    run_desc(8'd2, 1'b0, 1'b1, 1'b0, -1);
    for (int i = 0; i < 30; i++) begin
      run_desc(8'($urandom_range(12, 1)),
               $urandom_range(5) == 0,
               $urandom_range(3) != 0,
               $urandom_range(2) == 0,
               ($urandom_range(7) == 0) ? int'($urandom_range(3)) : -1);
    end
    r_dp_valid_i = 1'b0;
    @(negedge clk_i);
    check_idle("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
